// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the message sources / TX shifter and the UART TX scheduler.
// master = scheduler side, slave = sources plus shifter side.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 timeout_pulse;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_start, tx_data, timeout_pulse
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_start, tx_data, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Message-granular round-robin sharing of one UART TX shifter, with a stall watchdog.
// Optional UART_SCHED_PRIO0_EN: requester 0 wins every arbitration and never moves the RR pointer.
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int MSG_TIMEOUT = 4096
) (
  input logic               i_clk,
  input logic               i_rst_n,
  uart_tx_scheduler_if.master io_bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MSG_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_ACK, S_DONE} state_t;

  state_t             r_state, w_state;
  logic [NUM_REQ-1:0] r_grant, w_grant;
  logic [PW-1:0]      r_gidx, w_gidx;
  logic [PW-1:0]      r_ptr, w_ptr;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic [7:0]         r_tx_data, w_tx_data;
  logic               r_last, w_last;
  logic               r_tx_start, w_tx_start;
  logic               r_timeout, w_timeout;

  logic [NUM_REQ-1:0] w_rr_req;
  logic               w_rr_vld;
  logic [PW-1:0]      w_rr_idx;
  logic               w_win_vld;
  logic [PW-1:0]      w_win_idx;
  logic [PW-1:0]      w_rel_ptr;
  logic               w_accept;

`ifdef UART_SCHED_PRIO0_EN
  assign w_rr_req  = io_bus.req_valid & ~NUM_REQ'(1);
  assign w_win_vld = |io_bus.req_valid;
  assign w_win_idx = io_bus.req_valid[0] ? '0 : w_rr_idx;
  // Requester 0 wins outside the rotation, so its grants leave the pointer alone.
  assign w_rel_ptr = (r_gidx == '0) ? r_ptr : r_gidx;
`else
  assign w_rr_req  = io_bus.req_valid;
  assign w_win_vld = w_rr_vld;
  assign w_win_idx = w_rr_idx;
  assign w_rel_ptr = r_gidx;
`endif

  // First requesting index searching upward from pointer+1, wrapping at NUM_REQ.
  always_comb begin
    logic [PW:0] v_sum;
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    v_sum    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (v_sum >= (PW+1)'(NUM_REQ)) v_sum = v_sum - (PW+1)'(NUM_REQ);
      if (!w_rr_vld && w_rr_req[v_sum[PW-1:0]]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = v_sum[PW-1:0];
      end
    end
  end

  assign w_accept = (r_state == S_SEND) && io_bus.req_valid[r_gidx] && !io_bus.tx_busy;

  always_comb begin
    w_state    = r_state;
    w_grant    = r_grant;
    w_gidx     = r_gidx;
    w_ptr      = r_ptr;
    w_cnt      = r_cnt;
    w_tx_data  = r_tx_data;
    w_last     = r_last;
    w_tx_start = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (w_win_vld) begin
          w_grant = NUM_REQ'(1) << w_win_idx;
          w_gidx  = w_win_idx;
          w_state = S_SEND;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          w_tx_data  = io_bus.req_data[{r_gidx, 3'b000} +: 8];
          w_last     = io_bus.req_last[r_gidx];
          w_tx_start = 1'b1;
          w_cnt      = '0;
          w_state    = S_ACK;
        end else if (r_cnt == CW'(MSG_TIMEOUT - 1)) begin
          w_grant   = '0;
          w_ptr     = w_rel_ptr;
          w_timeout = 1'b1;
          w_cnt     = '0;
          w_state   = S_IDLE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_ACK: begin
        if (io_bus.tx_busy) w_state = S_DONE;
      end
      S_DONE: begin
        if (!io_bus.tx_busy) begin
          if (r_last) begin
            w_grant = '0;
            w_ptr   = w_rel_ptr;
            w_state = S_IDLE;
          end else begin
            w_state = S_SEND;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_ptr      <= PW'(NUM_REQ - 1);
      r_cnt      <= '0;
      r_tx_data  <= 8'h00;
      r_last     <= 1'b0;
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_grant    <= w_grant;
      r_gidx     <= w_gidx;
      r_ptr      <= w_ptr;
      r_cnt      <= w_cnt;
      r_tx_data  <= w_tx_data;
      r_last     <= w_last;
      r_tx_start <= w_tx_start;
      r_timeout  <= w_timeout;
    end
  end

  assign io_bus.req_ready     = w_accept ? r_grant : '0;
  assign io_bus.grant         = r_grant;
  assign io_bus.tx_start      = r_tx_start;
  assign io_bus.tx_data       = r_tx_data;
  assign io_bus.timeout_pulse = r_timeout;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: a per-cycle vector table for round-robin timing, then scripted message scenarios.
module tb_uart_tx_scheduler;
  localparam int NR   = 3;
  localparam int TMO  = 16;
  localparam int BLEN = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NR), .MSG_TIMEOUT(TMO)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  // TX shifter stand-in: busy rises the cycle after tx_start and stays high BLEN cycles.
  logic busy_auto = 1'b0;
  logic busy_man  = 1'b0;
  logic busy_mdl  = 1'b0;
  logic st_seen   = 1'b0;
  int   bcnt      = 0;
  assign bus.tx_busy = busy_auto ? busy_mdl : busy_man;

  always @(posedge clk) begin
    #1;
    if (st_seen) begin
      busy_mdl = 1'b1;
      bcnt     = BLEN;
    end else if (bcnt > 1) begin
      bcnt = bcnt - 1;
    end else begin
      busy_mdl = 1'b0;
      bcnt     = 0;
    end
    st_seen = bus.tx_start;
  end

  typedef struct packed {
    logic       rst;
    logic [2:0] vld;
    logic [2:0] lst;
    logic       busy;
    logic [2:0] grant;
    logic [2:0] rdy;
    logic       start;
    logic [7:0] data;
    logic       tp;
  } vec_t;

  vec_t tbl [22];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scripted message sources plus event logs.
  int         len  [NR];
  int         pos  [NR];
  bit         en   [NR];
  bit         term [NR];
  bit         rep  [NR];
  logic [7:0] mb   [NR][4];

  int         cyc = 0;
  int         nstart, ntp, tp_cyc, bfall_cyc, g0_cyc;
  int         nviol = 0;
  int         nrdy [NR];
  logic [7:0] slog [8];
  logic [2:0] glog [$];
  logic [2:0] prev_grant = '0;
  logic       prev_busy  = 1'b0;

  function automatic logic [2:0] gl(input int k);
    return (glog.size() > k) ? glog[k] : 3'b111;
  endfunction

  task automatic clear_logs();
    nstart = 0; ntp = 0; tp_cyc = -1; bfall_cyc = -1; g0_cyc = -1;
    glog.delete();
    for (int i = 0; i < NR; i++) nrdy[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]       = en[i] && (pos[i] < len[i]);
      bus.req_data[8*i +: 8] = mb[i][(pos[i] < 4) ? pos[i] : 0];
      bus.req_last[i]        = term[i] && (pos[i] == len[i] - 1);
    end
  endtask

  task automatic run(input int n);
    drive();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        if (nstart < 8) slog[nstart] = bus.tx_data;
        nstart++;
      end
      if (bus.timeout_pulse) begin ntp++; tp_cyc = cyc; end
      if (prev_busy && !bus.tx_busy) bfall_cyc = cyc;
      prev_busy = bus.tx_busy;
      if (bus.grant !== prev_grant) begin
        glog.push_back(bus.grant);
        if (bus.grant == '0) g0_cyc = cyc;
        prev_grant = bus.grant;
      end
      if (((bus.req_ready & ~bus.grant) != '0) || ($countones(bus.req_ready) > 1)) nviol++;
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i]) begin
          nrdy[i]++;
          pos[i]++;
          if (rep[i] && pos[i] >= len[i]) pos[i] = 0;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      drive();
    end
  endtask

  initial begin
    int n001, n010;
    logic [2:0] first_nz;

    tbl[0]  = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b001, 3'b001, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b001, 3'b000, 1'b1, 8'hA0, 1'b0};
    tbl[4]  = '{1'b1, 3'b111, 3'b111, 1'b1, 3'b001, 3'b000, 1'b0, 8'hA0, 1'b0};
    tbl[5]  = '{1'b1, 3'b111, 3'b111, 1'b1, 3'b001, 3'b000, 1'b0, 8'hA0, 1'b0};
    tbl[6]  = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b001, 3'b000, 1'b0, 8'hA0, 1'b0};
    tbl[7]  = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 8'hA0, 1'b0};
    tbl[8]  = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b010, 3'b010, 1'b0, 8'hA0, 1'b0};
    tbl[9]  = '{1'b1, 3'b111, 3'b111, 1'b1, 3'b010, 3'b000, 1'b1, 8'hB1, 1'b0};
    tbl[10] = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b010, 3'b000, 1'b0, 8'hB1, 1'b0};
    tbl[11] = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 8'hB1, 1'b0};
    tbl[12] = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b100, 3'b100, 1'b0, 8'hB1, 1'b0};
    tbl[13] = '{1'b1, 3'b111, 3'b111, 1'b1, 3'b100, 3'b000, 1'b1, 8'hC2, 1'b0};
    tbl[14] = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b100, 3'b000, 1'b0, 8'hC2, 1'b0};
    tbl[15] = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 8'hC2, 1'b0};
    tbl[16] = '{1'b1, 3'b111, 3'b111, 1'b1, 3'b001, 3'b000, 1'b0, 8'hC2, 1'b0};
    tbl[17] = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b001, 3'b001, 1'b0, 8'hC2, 1'b0};
    tbl[18] = '{1'b1, 3'b111, 3'b111, 1'b1, 3'b001, 3'b000, 1'b1, 8'hA0, 1'b0};
    tbl[19] = '{1'b1, 3'b111, 3'b111, 1'b0, 3'b001, 3'b000, 1'b0, 8'hA0, 1'b0};
    tbl[20] = '{1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 8'hA0, 1'b0};
    tbl[21] = '{1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 8'hA0, 1'b0};

    for (int i = 0; i < NR; i++) begin
      len[i] = 0; pos[i] = 0; en[i] = 1'b0; term[i] = 1'b1; rep[i] = 1'b0;
      for (int j = 0; j < 4; j++) mb[i][j] = 8'h00;
    end
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = {8'hC2, 8'hB1, 8'hA0};
    clear_logs();
    repeat (2) @(posedge clk);
    #1;

`ifndef UART_SCHED_PRIO0_EN
    // Round-robin timing, all sources valid with single-byte messages.
    for (int i = 0; i < 22; i++) begin
      rst_n         = tbl[i].rst;
      bus.req_valid = tbl[i].vld;
      bus.req_last  = tbl[i].lst;
      busy_man      = tbl[i].busy;
      @(negedge clk);
      chk($sformatf("vec%0d grant", i), 32'(bus.grant), 32'(tbl[i].grant));
      chk($sformatf("vec%0d ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d tx_start", i), 32'(bus.tx_start), 32'(tbl[i].start));
      chk($sformatf("vec%0d tx_data", i), 32'(bus.tx_data), 32'(tbl[i].data));
      chk($sformatf("vec%0d timeout", i), 32'(bus.timeout_pulse), 32'(tbl[i].tp));
      @(posedge clk);
      #1;
    end
`else
    rst_n = 1'b1;
    chk("prio reset grant", 32'(bus.grant), 32'h0);
`endif
    busy_auto = 1'b1;

    // "HI" from requester 0.
    en[0] = 1; len[0] = 2; term[0] = 1; pos[0] = 0; mb[0][0] = 8'h48; mb[0][1] = 8'h49;
    clear_logs();
    run(45);
    chk("t1 starts", nstart, 2);
    chk("t1 byte0", 32'(slog[0]), 32'h48);
    chk("t1 byte1", 32'(slog[1]), 32'h49);
    chk("t1 grant0", 32'(gl(0)), 32'h1);
    chk("t1 grant1", 32'(gl(1)), 32'h0);
    chk("t1 glog len", glog.size(), 2);
    chk("t1 ready0", nrdy[0], 2);
    chk("t1 release after busy fall", g0_cyc - bfall_cyc, 1);

    // Requester 1 mid-message, requester 0 arrives: no preemption.
    en[0] = 0;
    en[1] = 1; len[1] = 3; term[1] = 1; pos[1] = 0;
    mb[1][0] = 8'h11; mb[1][1] = 8'h12; mb[1][2] = 8'h13;
    clear_logs();
    run(3);
    en[0] = 1; len[0] = 1; term[0] = 1; pos[0] = 0; mb[0][0] = 8'h55;
    run(80);
    chk("t3 grant0", 32'(gl(0)), 32'h2);
    chk("t3 grant1", 32'(gl(1)), 32'h0);
    chk("t3 grant2", 32'(gl(2)), 32'h1);
    chk("t3 grant3", 32'(gl(3)), 32'h0);
    chk("t3 starts", nstart, 4);
    chk("t3 req1 last byte", 32'(slog[2]), 32'h13);
    chk("t3 req0 byte", 32'(slog[3]), 32'h55);
    chk("t3 ready1", nrdy[1], 3);

    // Requester 2 stalls after a non-last byte.
    en[0] = 0; en[1] = 0;
    en[2] = 1; len[2] = 1; term[2] = 0; pos[2] = 0; mb[2][0] = 8'h77;
    clear_logs();
    run(40);
    chk("t4 timeout count", ntp, 1);
    chk("t4 timeout delay", tp_cyc - bfall_cyc, 17);
    chk("t4 grant0", 32'(gl(0)), 32'h4);
    chk("t4 grant1", 32'(gl(1)), 32'h0);
    chk("t4 starts", nstart, 1);
    chk("t4 byte", 32'(slog[0]), 32'h77);
    en[0] = 1; len[0] = 1; term[0] = 1; pos[0] = 0; mb[0][0] = 8'hA5;
    en[1] = 1; len[1] = 1; term[1] = 1; pos[1] = 0; mb[1][0] = 8'h5A;
    clear_logs();
    run(40);
    chk("t4 next grant", 32'(gl(0)), 32'h1);
    chk("t4 then idle", 32'(gl(1)), 32'h0);
    chk("t4 then req1", 32'(gl(2)), 32'h2);
    chk("t4 no new timeout", ntp, 0);

    // Asynchronous reset while in DONE.
    en[0] = 0; en[2] = 0;
    en[1] = 1; len[1] = 2; term[1] = 1; pos[1] = 0; mb[1][0] = 8'h21; mb[1][1] = 8'h22;
    clear_logs();
    run(7);
    chk("t5 pre grant", 32'(bus.grant), 32'h2);
    chk("t5 pre data", 32'(bus.tx_data), 32'h21);
    rst_n = 1'b0;
    #1;
    chk("t5 rst grant", 32'(bus.grant), 32'h0);
    chk("t5 rst tx_start", 32'(bus.tx_start), 32'h0);
    chk("t5 rst tx_data", 32'(bus.tx_data), 32'h0);
    chk("t5 rst timeout", 32'(bus.timeout_pulse), 32'h0);
    en[1] = 0;
    run(3);
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      en[i] = 1; len[i] = 1; term[i] = 1; pos[i] = 0; mb[i][0] = 8'(8'h60 + i);
    end
    clear_logs();
    run(20);
    chk("t5 first winner", 32'(gl(0)), 32'h1);

`ifdef UART_SCHED_PRIO0_EN
    // Requester 0 fixed priority.
    for (int i = 0; i < NR; i++) en[i] = 0;
    run(50);
    en[0] = 1; rep[0] = 1; len[0] = 1; pos[0] = 0;
    en[1] = 1; rep[1] = 1; len[1] = 1; pos[1] = 0;
    clear_logs();
    run(70);
    n001 = 0; n010 = 0;
    foreach (glog[k]) begin
      if (glog[k] == 3'b001) n001++;
      if (glog[k] == 3'b010) n010++;
    end
    chk("t6 req1 never", n010, 0);
    chk("t6 req0 repeated", 32'(n001 >= 3), 32'h1);
    en[0] = 0;
    clear_logs();
    run(50);
    first_nz = 3'b111;
    for (int k = glog.size() - 1; k >= 0; k--) if (glog[k] != 3'b000) first_nz = glog[k];
    chk("t6 req1 after drop", 32'(first_nz), 32'h2);
`endif

    chk("ready only for owner", nviol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
